// File: rtl/module_control_regfile_pkg.sv
// Shared types for the register-file command sequencer: data/address types, ops and FSM states.
package module_control_regfile_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned CntW  = 16;

  typedef logic [DataW-1:0] bits_t;
  typedef logic [AddrW-1:0] bitsh_t;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpAnd = 2'd2,
    OpLdi = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StExec  = 2'd2,
    StWrite = 2'd3
  } state_t;

endpackage

// File: rtl/module_alu_regfile.sv
// Combinational ALU for the sequencer; LDI passes operand b through (b carries the immediate).
module module_alu_regfile
  import module_control_regfile_pkg::*;
#(
  parameter int unsigned W = DataW
) (
  input  op_t          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OpAdd: y_o = a_i + b_i;
      OpSub: y_o = a_i - b_i;
      OpAnd: y_o = a_i & b_i;
      OpLdi: y_o = b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/module_control_regfile.sv
// Command sequencer and sole master of the 2R/1W register file: read, compute, write back.
module module_control_regfile
  import module_control_regfile_pkg::*;
#(
  parameter int unsigned W     = DataW,
  parameter int unsigned N     = AddrW,
  parameter int unsigned CNT_W = CntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [N-1:0]     cmd_rd_i,
  input  logic [N-1:0]     cmd_rs1_i,
  input  logic [N-1:0]     cmd_rs2_i,
  input  logic [W-1:0]     cmd_imm_i,
  output logic             rf_we_o,
  output logic [N-1:0]     rf_rs1_o,
  output logic [N-1:0]     rf_rs2_o,
  output logic [N-1:0]     rf_rd_o,
  output logic [W-1:0]     rf_data_o,
  input  logic [W-1:0]     rf_rs1_i,
  input  logic [W-1:0]     rf_rs2_i,
  output logic             done_o,
  output logic [W-1:0]     result_o,
  output logic [CNT_W-1:0] cnt_o
);

  state_t             state_q, state_d;
  op_t                op_q;
  logic [N-1:0]       rd_q, rs1_q, rs2_q;
  logic [W-1:0]       imm_q;
  logic [W-1:0]       a_q, b_q;
  logic [W-1:0]       result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       alu_b;
  logic [W-1:0]       alu_y;
  logic               accept;

  assign accept = (state_q == StIdle) && cmd_valid_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d = (op_t'(cmd_op_i) == OpLdi) ? StExec : StRead;
        end
      end
      StRead:  state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_t'(cmd_op_i);
        rd_q  <= cmd_rd_i;
        rs1_q <= cmd_rs1_i;
        rs2_q <= cmd_rs2_i;
        imm_q <= cmd_imm_i;
      end
      if (state_q == StRead) begin
        a_q <= rf_rs1_i;
        b_q <= rf_rs2_i;
      end
      if (state_q == StExec) begin
        result_q <= alu_y;
      end
      if (state_q == StWrite) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // LDI skips READ, so the immediate takes operand b's place.
  assign alu_b = (op_q == OpLdi) ? imm_q : b_q;

  module_alu_regfile #(
    .W (W)
  ) u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  assign cmd_ready_o = (state_q == StIdle);
  assign done_o      = (state_q == StWrite);
  assign rf_we_o     = (state_q == StWrite) && (rd_q != '0);
  assign rf_rs1_o    = rs1_q;
  assign rf_rs2_o    = rs2_q;
  assign rf_rd_o     = rd_q;
  assign rf_data_o   = result_q;
  assign result_o    = result_q;
  assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_module_control_regfile.sv
// Self-checking bench: behavioural register file plus a command-level reference model.
module tb_module_control_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0] cmd_imm;
  logic        rf_we;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_data, rf_rs1_d, rf_rs2_d;
  logic        done;
  logic [31:0] result;
  logic [15:0] cnt;

  logic [31:0] mem [32] = '{default: '0};
  logic [31:0] ref_regs [32];
  logic [15:0] ref_cnt;
  logic [31:0] ref_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Register file stand-in: combinational reads, synchronous write.
  always @(posedge clk) if (rf_we) mem[rf_rd] <= rf_data;
  assign rf_rs1_d = mem[rf_rs1];
  assign rf_rs2_d = mem[rf_rs2];

  module_control_regfile dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_rd_i    (cmd_rd),
    .cmd_rs1_i   (cmd_rs1),
    .cmd_rs2_i   (cmd_rs2),
    .cmd_imm_i   (cmd_imm),
    .rf_we_o     (rf_we),
    .rf_rs1_o    (rf_rs1),
    .rf_rs2_o    (rf_rs2),
    .rf_rd_o     (rf_rd),
    .rf_data_o   (rf_data),
    .rf_rs1_i    (rf_rs1_d),
    .rf_rs2_i    (rf_rs2_d),
    .done_o      (done),
    .result_o    (result),
    .cnt_o       (cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return imm;
    endcase
  endfunction

  function automatic void model_commit(input logic [4:0] rd, input logic [31:0] y);
    if (rd != 5'd0) ref_regs[rd] = y;
    ref_cnt    = ref_cnt + 16'd1;
    ref_result = y;
  endfunction

  // Issues one command and checks latency, write-port values and the committed state.
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input bit noise);
    int          w;
    int          k;
    bit          seen;
    logic [31:0] exp_y;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    exp_y = model_op(op, ref_regs[rs1], ref_regs[rs2], imm);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
      else if (noise) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_rd    = 5'($urandom_range(0, 31));
        cmd_rs1   = 5'($urandom_range(0, 31));
        cmd_rs2   = 5'($urandom_range(0, 31));
        cmd_imm   = $urandom;
      end
    end
    check("done_latency", k, (op == 2'd3) ? 32'd2 : 32'd3);
    check("write_en", 32'(rf_we), 32'(rd != 5'd0));
    check("write_data", rf_data, exp_y);
    check("write_addr", 32'(rf_rd), 32'(rd));
    check("result", result, exp_y);
    model_commit(rd, exp_y);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("regfile", mem[rd], ref_regs[rd]);
    check("cnt", 32'(cnt), 32'(ref_cnt));
    check("done_clear", 32'(done), 32'd0);
    check("ready_back", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_y;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    ref_cnt = 16'd0;
    ref_result = 32'd0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_rd = 5'd0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_imm = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rf_rd), 32'd0);
    rst = 1'b1;

    // Directed: loads, ALU ops incl. wrap, AND, write to x0.
    do_cmd(2'd3, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 1'b0);
    check("x1_is_5", mem[1], 32'd5);
    do_cmd(2'd3, 5'd2, 5'd0, 5'd0, 32'h0000_0003, 1'b0);
    do_cmd(2'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0);
    check("x3_is_8", mem[3], 32'd8);
    do_cmd(2'd1, 5'd4, 5'd2, 5'd1, 32'h0, 1'b0);
    check("x4_wrap", mem[4], 32'hFFFF_FFFE);
    do_cmd(2'd2, 5'd5, 5'd1, 5'd3, 32'h0, 1'b0);
    check("x5_is_0", mem[5], 32'd0);
    do_cmd(2'd3, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, 1'b0);
    check("x0_is_0", mem[0], 32'd0);

    // Back-to-back with valid held; x7 accumulates x1, exercising read-after-write.
    @(negedge clk);
    cmd_op = 2'd0; cmd_rd = 5'd7; cmd_rs1 = 5'd7; cmd_rs2 = 5'd1; cmd_imm = 32'd0;
    cmd_valid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      check("b2b_ready", 32'(cmd_ready), 32'((t % 4) == 0));
      check("b2b_done", 32'(done), 32'((t % 4) == 3));
      if ((t % 4) == 3) begin
        exp_y = ref_regs[7] + ref_regs[1];
        check("b2b_data", rf_data, exp_y);
        model_commit(5'd7, exp_y);
      end
      if (t == 11) cmd_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_x7", mem[7], ref_regs[7]);
    check("b2b_cnt", 32'(cnt), 32'(ref_cnt));

    // Reset while in EXEC: no write, counters and result cleared.
    cmd_op = 2'd0; cmd_rd = 5'd6; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("exec_no_done", 32'(done), 32'd0);
    check("exec_no_we", 32'(rf_we), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_we", 32'(rf_we), 32'd0);
    check("mid_rst_cnt", 32'(cnt), 32'd0);
    check("mid_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ref_cnt = 16'd0;
    ref_result = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
    end
    check("x6_unchanged", mem[6], ref_regs[6]);

    // Randomized commands, some with spurious valid pulses while busy.
    for (int n = 0; n < 40; n++) begin
      do_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
    end
    check("final_result", result, ref_result);
    for (int i = 0; i < 32; i++) check("final_reg", mem[i], ref_regs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
